alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the SISC datapath: the next generation of the single-cycle ALU. It adds width/immediate parametrisation, a start/busy/done handshake, bit-serial shifts and rotates (one bit per cycle), and an optional shift-add multiplier. It sits between the register file and the writeback mux. The control unit holds off writeback and status update until `done`.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_comb.sv | 102 ++++++++++
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the SISC multi-cycle ALU: function codes, mode codes,
// FSM state encoding, status bit positions and status-update masks.
package alu_pkg;

    localparam logic [3:0] F_MUL = 4'd0;
    localparam logic [3:0] F_ADD = 4'd1;
    localparam logic [3:0] F_SUB = 4'd2;
    localparam logic [3:0] F_ADC = 4'd3;
    localparam logic [3:0] F_NOT = 4'd4;
    localparam logic [3:0] F_OR  = 4'd5;
    localparam logic [3:0] F_AND = 4'd6;
    localparam logic [3:0] F_XOR = 4'd7;
    localparam logic [3:0] F_ROR = 4'd8;
    localparam logic [3:0] F_ROL = 4'd9;
    localparam logic [3:0] F_SHR = 4'd10;
    localparam logic [3:0] F_SHL = 4'd11;
    localparam logic [3:0] F_RRC = 4'd12;
    localparam logic [3:0] F_RLC = 4'd13;
    localparam logic [3:0] F_ASR = 4'd14;
    localparam logic [3:0] F_ASL = 4'd15;

    localparam logic [2:0] M_FC    = 3'b000;
    localparam logic [2:0] M_FCI   = 3'b001;
    localparam logic [2:0] M_ADDI  = 3'b010;
    localparam logic [2:0] M_SUBI  = 3'b011;
    localparam logic [2:0] M_INC   = 3'b100;
    localparam logic [2:0] M_DEC   = 3'b101;
    localparam logic [2:0] M_PASSA = 3'b110;
    localparam logic [2:0] M_PASSB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    localparam int ST_C = 3;
    localparam int ST_V = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    localparam logic [3:0] UPD_ALL  = 4'b1111;
    localparam logic [3:0] UPD_CNZ  = 4'b1011;
    localparam logic [3:0] UPD_NZ   = 4'b0011;
    localparam logic [3:0] UPD_NONE = 4'b0000;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: operand-B select, add/sub, logic unit, flags and
// status-update mask. ALU_SEQ_MUL_EN selects the update mask for funct 0.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   rsb,
    input  logic [IMM_W-1:0]   imm,
    input  logic               c_in,
    input  logic [2:0]         mode,
    input  logic [3:0]         funct,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags,
    output logic [3:0]         sts_upd,
    output logic               is_shift,
    output logic [SHAMT_W-1:0] shamt
);

    logic [WIDTH-1:0] imm_x;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_op;
    logic             sub_op;
    logic             cin_add;
    logic             c_flag;
    logic             v_flag;

    always_comb begin
        imm_x    = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        opb      = (mode == M_FCI) ? imm_x : rsb;
        b_eff    = opb;
        add_op   = 1'b0;
        sub_op   = 1'b0;
        cin_add  = 1'b0;
        result   = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        sum      = '0;
        sts_upd  = UPD_CNZ;
        is_shift = 1'b0;
        case (mode)
            M_ADDI:  begin b_eff = imm_x;     add_op = 1'b1; end
            M_SUBI:  begin b_eff = imm_x;     sub_op = 1'b1; end
            M_INC:   begin b_eff = WIDTH'(1); add_op = 1'b1; end
            M_DEC:   begin b_eff = WIDTH'(1); sub_op = 1'b1; end
            M_PASSA: result = a;
            M_PASSB: result = opb;
            default: begin
                case (funct[3:2])
                    2'b00:   sts_upd = UPD_ALL;
                    2'b01:   sts_upd = UPD_NZ;
                    2'b10:   sts_upd = UPD_NZ;
                    default: sts_upd = UPD_CNZ;
                endcase
                case (funct)
                    F_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                        sts_upd = UPD_CNZ;
`else
                        sts_upd = UPD_NONE;
`endif
                    end
                    F_ADD: add_op = 1'b1;
                    F_SUB: sub_op = 1'b1;
                    F_ADC: begin add_op = 1'b1; cin_add = c_in; end
                    F_NOT: result = ~a;
                    F_OR:  result = a | opb;
                    F_AND: result = a & opb;
                    F_XOR: result = a ^ opb;
                    default: begin
                        // zero-distance shift: pass A, carry only survives the through-carry rotates
                        is_shift = 1'b1;
                        result   = a;
                        c_flag   = (funct == F_RRC || funct == F_RLC) ? c_in : 1'b0;
                    end
                endcase
            end
        endcase

        // C is bit WIDTH of the unsigned sum/difference, i.e. borrow on subtract
        if (add_op) begin
            sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_add};
            v_flag = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (sub_op) begin
            sum    = {1'b0, a} - {1'b0, b_eff};
            v_flag = (a[WIDTH-1] != b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        if (add_op || sub_op) begin
            result = sum[WIDTH-1:0];
            c_flag = sum[WIDTH];
        end
    end

    assign shamt = opb[SHAMT_W-1:0];
    assign flags = {c_flag, v_flag, result[WIDTH-1], result == '0};

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake and bit-serial shifts.
// Defining ALU_SEQ_MUL_EN adds a shift-add multiplier on funct 0.
//
// state   | meaning
// S_IDLE  | accepts start; single-cycle ops complete here
// S_SHIFT | one shift/rotate bit per cycle until the down-counter hits 0
// S_MUL   | one shift-add iteration per cycle, WIDTH iterations
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rsa,
    input  logic [WIDTH-1:0] rsb,
    input  logic [IMM_W-1:0] imm,
    input  logic             c_in,
    input  logic [3:0]       alu_op,
    input  logic [3:0]       funct,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       stat,
    output logic [3:0]       stat_en
);

    logic [WIDTH-1:0]   c_result;
    logic [3:0]         c_flags;
    logic [3:0]         c_upd;
    logic               c_is_shift;
    logic [SHAMT_W-1:0] c_shamt;

    alu_comb #(.WIDTH(WIDTH), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W)) u_comb (
        .a        (rsa),
        .rsb      (rsb),
        .imm      (imm),
        .c_in     (c_in),
        .mode     (alu_op[3:1]),
        .funct    (funct),
        .result   (c_result),
        .flags    (c_flags),
        .sts_upd  (c_upd),
        .is_shift (c_is_shift),
        .shamt    (c_shamt)
    );

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         stat_q, stat_d;
    logic [3:0]         stat_en_q, stat_en_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               cy_q, cy_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         funct_q, funct_d;
    logic [3:0]         upd_q, upd_d;
    logic [WIDTH-1:0]   sh_nx;
    logic               cy_nx;

    always_comb begin
        sh_nx = sh_q;
        cy_nx = cy_q;
        case (funct_q)
            F_ROR:   begin cy_nx = sh_q[0];       sh_nx = {sh_q[0], sh_q[WIDTH-1:1]};       end
            F_ROL:   begin cy_nx = sh_q[WIDTH-1]; sh_nx = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; end
            F_SHR:   begin cy_nx = sh_q[0];       sh_nx = {1'b0, sh_q[WIDTH-1:1]};          end
            F_RRC:   begin cy_nx = sh_q[0];       sh_nx = {cy_q, sh_q[WIDTH-1:1]};          end
            F_RLC:   begin cy_nx = sh_q[WIDTH-1]; sh_nx = {sh_q[WIDTH-2:0], cy_q};          end
            F_ASR:   begin cy_nx = sh_q[0];       sh_nx = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; end
            default: begin cy_nx = sh_q[WIDTH-1]; sh_nx = {sh_q[WIDTH-2:0], 1'b0};          end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mhi_q, mhi_d;
    logic [WIDTH-1:0] mhi_nx, mlo_nx;
    logic [WIDTH:0]   mac;
    logic             is_mul;
    logic [WIDTH-1:0] mul_b;

    assign is_mul = (alu_op[3:2] == 2'b00) && (funct == F_MUL);
    assign mul_b  = alu_op[1] ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : rsb;

    // {hi, lo} shifts right each step; lo starts as the multiplier in sh_q
    always_comb begin
        mac    = {1'b0, mhi_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
        mhi_nx = mac[WIDTH:1];
        mlo_nx = {mac[0], sh_q[WIDTH-1:1]};
    end
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        stat_d    = stat_q;
        stat_en_d = '0;
        sh_d      = sh_q;
        cy_d      = cy_q;
        cnt_d     = cnt_q;
        funct_d   = funct_q;
        upd_d     = upd_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d   = mcand_q;
        mhi_d     = mhi_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    funct_d = funct;
                    upd_d   = alu_op[0] ? c_upd : '0;
`ifdef ALU_SEQ_MUL_EN
                    if (is_mul) begin
                        sh_d    = mul_b;
                        mcand_d = rsa;
                        mhi_d   = '0;
                        cnt_d   = SHAMT_W'(WIDTH-1);
                        busy_d  = 1'b1;
                        state_d = S_MUL;
                    end else
`endif
                    if (c_is_shift && c_shamt != '0) begin
                        sh_d    = rsa;
                        cy_d    = c_in;
                        cnt_d   = c_shamt - 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        result_d  = c_result;
                        stat_d    = c_flags;
                        stat_en_d = alu_op[0] ? c_upd : '0;
                        done_d    = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                sh_d  = sh_nx;
                cy_d  = cy_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d  = sh_nx;
                    stat_d    = {cy_nx, 1'b0, sh_nx[WIDTH-1], sh_nx == '0};
                    stat_en_d = upd_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                sh_d  = mlo_nx;
                mhi_d = mhi_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d  = mlo_nx;
                    stat_d    = {|mhi_nx, 1'b0, mlo_nx[WIDTH-1], mlo_nx == '0};
                    stat_en_d = upd_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            stat_q    <= '0;
            stat_en_q <= '0;
            sh_q      <= '0;
            cy_q      <= 1'b0;
            cnt_q     <= '0;
            funct_q   <= '0;
            upd_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= '0;
            mhi_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            stat_q    <= stat_d;
            stat_en_q <= stat_en_d;
            sh_q      <= sh_d;
            cy_q      <= cy_d;
            cnt_q     <= cnt_d;
            funct_q   <= funct_d;
            upd_q     <= upd_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= mcand_d;
            mhi_q     <= mhi_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign alu_result = result_q;
    assign stat       = stat_q;
    assign stat_en    = stat_en_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (default parameters).
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] rsa = '0;
    logic [31:0] rsb = '0;
    logic [15:0] imm = '0;
    logic        c_in = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [3:0]  funct = '0;
    logic        busy;
    logic        done;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic [3:0]  stat_en;

    int n_vec = 0;
    int n_err = 0;

    alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rsa        (rsa),
        .rsb        (rsb),
        .imm        (imm),
        .c_in       (c_in),
        .alu_op     (alu_op),
        .funct      (funct),
        .busy       (busy),
        .done       (done),
        .alu_result (alu_result),
        .stat       (stat),
        .stat_en    (stat_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im, input logic ci);
        alu_op = op;
        funct  = fn;
        rsa    = a;
        rsb    = b;
        imm    = im;
        c_in   = ci;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                       input logic ci, input int exp_lat, input logic [31:0] exp_res,
                       input logic [3:0] exp_st, input logic [3:0] exp_en);
        int lat;
        int bcnt;
        @(negedge clk);
        drive(op, fn, a, b, im, ci);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(bcnt), (exp_lat > 1) ? 32'(exp_lat) : 32'd0);
        chk({tag, "_result"}, alu_result, exp_res);
        chk({tag, "_stat"}, {28'd0, stat}, {28'd0, exp_st});
        chk({tag, "_stat_en"}, {28'd0, stat_en}, {28'd0, exp_en});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        int first;
        logic [31:0] res_seen;
        logic [3:0]  st_seen;
        logic [3:0]  en_seen;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_stat", {28'd0, stat}, 32'd0);
        chk("rst_stat_en", {28'd0, stat_en}, 32'd0);
        @(negedge clk) rst = 1'b0;

        run("add_ovf", 4'b0001, 4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, 1'b0, 1, 32'h8000_0000, 4'b0110, 4'b1111);
        run("ror4",    4'b0001, 4'd8, 32'h0000_0001, 32'h0000_0004, 16'h0, 1'b0, 5, 32'h1000_0000, 4'b0000, 4'b0011);
        run("rlc1",    4'b0001, 4'd13, 32'h8000_0000, 32'h0000_0001, 16'h0, 1'b1, 2, 32'h0000_0001, 4'b1000, 4'b1011);
        run("subi",    4'b0011, 4'd2, 32'h0000_0005, 32'h0000_0000, 16'hFFFF, 1'b0, 1, 32'h0000_0006, 4'b1000, 4'b1111);
        run("adc",     4'b0001, 4'd3, 32'hFFFF_FFFF, 32'h0000_0000, 16'h0, 1'b1, 1, 32'h0000_0000, 4'b1001, 4'b1111);
        run("xor",     4'b0001, 4'd7, 32'hF0F0_F0F0, 32'hFFFF_0000, 16'h0, 1'b0, 1, 32'h0F0F_F0F0, 4'b0000, 4'b0011);
        run("and_nou", 4'b0000, 4'd6, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 16'h0, 1'b0, 1, 32'h0000_0000, 4'b0001, 4'b0000);
        run("not",     4'b0001, 4'd4, 32'h0000_0000, 32'h1234_5678, 16'h0, 1'b0, 1, 32'hFFFF_FFFF, 4'b0010, 4'b0011);
        run("asr4",    4'b0001, 4'd14, 32'h8000_0000, 32'h0000_0004, 16'h0, 1'b0, 5, 32'hF800_0000, 4'b0010, 4'b1011);
        run("rrc_k0",  4'b0001, 4'd12, 32'h1234_5678, 32'h0000_0020, 16'h0, 1'b1, 1, 32'h1234_5678, 4'b1000, 4'b1011);
        run("shl_k0",  4'b0001, 4'd11, 32'h8000_0001, 32'h0000_0040, 16'h0, 1'b1, 1, 32'h8000_0001, 4'b0010, 4'b0011);
        run("dec",     4'b1011, 4'd1, 32'h0000_0000, 32'h0000_0000, 16'h0, 1'b0, 1, 32'hFFFF_FFFF, 4'b1010, 4'b1011);
        run("addi",    4'b0101, 4'd0, 32'hFFFF_FFFF, 32'h0000_0000, 16'h0001, 1'b0, 1, 32'h0000_0000, 4'b1001, 4'b1011);
        run("pass_a",  4'b1101, 4'd5, 32'h1234_5678, 32'h0000_0000, 16'h0, 1'b0, 1, 32'h1234_5678, 4'b0000, 4'b1011);
        run("pass_b",  4'b1110, 4'd5, 32'hFFFF_FFFF, 32'h0000_0000, 16'h0, 1'b0, 1, 32'h0000_0000, 4'b0001, 4'b0000);
`ifdef ALU_SEQ_MUL_EN
        run("mul_big", 4'b0001, 4'd0, 32'h0001_0000, 32'h0001_0000, 16'h0, 1'b0, 33, 32'h0000_0000, 4'b1001, 4'b1011);
        run("mul_3x5", 4'b0001, 4'd0, 32'h0000_0003, 32'h0000_0005, 16'h0, 1'b0, 33, 32'h0000_000F, 4'b0000, 4'b1011);
`else
        run("mul_nop", 4'b0001, 4'd0, 32'h0001_0000, 32'h0001_0000, 16'h0, 1'b0, 1, 32'h0000_0000, 4'b0001, 4'b0000);
`endif

        // back-to-back single-cycle ops at full rate
        @(negedge clk);
        drive(4'b0001, 4'd1, 32'd1, 32'd2, 16'h0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_done0", {31'd0, done}, 32'd1);
        chk("b2b_res0", alu_result, 32'd3);
        @(negedge clk);
        drive(4'b0001, 4'd2, 32'd10, 32'd3, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_res1", alu_result, 32'd7);
        @(negedge clk);
        drive(4'b0001, 4'd5, 32'h0000_00F0, 32'h0000_000F, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_res2", alu_result, 32'h0000_00FF);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_idle", {31'd0, done}, 32'd0);

        // start pulses and input changes during a k=31 SHR are ignored
        @(negedge clk);
        drive(4'b0001, 4'd10, 32'h8000_0000, 32'd31, 16'h0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones    = 0;
        first    = 0;
        res_seen = '0;
        st_seen  = '0;
        en_seen  = '0;
        for (int i = 1; i <= 40; i++) begin
            if (done === 1'b1) begin
                dones++;
                if (first == 0) begin
                    first    = i;
                    res_seen = alu_result;
                    st_seen  = stat;
                    en_seen  = stat_en;
                end
            end
            @(negedge clk);
            if (i == 3 || i == 10) begin
                drive(4'b0001, 4'd1, 32'd5, 32'd0, 16'h0, 1'b1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("shr31_dones", 32'(dones), 32'd1);
        chk("shr31_lat", 32'(first), 32'd32);
        chk("shr31_result", res_seen, 32'h0000_0001);
        chk("shr31_stat", {28'd0, st_seen}, 32'd0);
        chk("shr31_stat_en", {28'd0, en_seen}, 32'h0000_0003);

        // reset in the middle of a k=20 SHL
        run("add_pre", 4'b0001, 4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, 1'b0, 1, 32'h8000_0000, 4'b0110, 4'b1111);
        @(negedge clk);
        drive(4'b0001, 4'd11, 32'h0000_0001, 32'd20, 16'h0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", alu_result, 32'd0);
        chk("abort_stat", {28'd0, stat}, 32'd0);
        chk("abort_stat_en", {28'd0, stat_en}, 32'd0);
        @(negedge clk) rst = 1'b0;
        dones = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run("add_post", 4'b0001, 4'd1, 32'd2, 32'd3, 16'h0, 1'b0, 1, 32'd5, 4'b0000, 4'b1111);

        // reset and start in the same cycle: request dropped
        @(negedge clk);
        drive(4'b0001, 4'd1, 32'd1, 32'd1, 16'h0, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_done", {31'd0, done}, 32'd0);
        chk("rst_start_result", alu_result, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_done2", {31'd0, done}, 32'd0);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
